// File: rtl/game_engine_np.sv
// rtl/game_engine_np.sv - N-player dice-race controller with traps, boosts and turn timeout
module game_engine_np #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BOARD_LEN       = 10,
  parameter int DICE_W          = 2,
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int LED_W           = 16,
  parameter int TRAP_TILE       = 4,
  parameter int BOOST_TILE      = 7,
  parameter int BOOST_AMT       = 2,
  parameter int EXACT_FINISH    = 0,
  parameter int MAX_IDLE_ROUNDS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_btn,
  input  logic                     dice_valid,
  input  logic [DICE_W-1:0]        dice_value,
  output logic [NUM_PLAYERS*4-1:0] pos_bus,
  output logic [1:0]               turn_id,
  output logic                     winner_valid,
  output logic [1:0]               winner_id,
  output logic [1:0]               event_code,
  output logic                     move_done,
  output logic [LED_W-1:0]         led_output
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DICE, S_MOVE, S_EVENT, S_NEXT_TURN, S_WIN
  } state_t;

  localparam int               TICK_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [7:0]       IDLE_LIMIT = 8'(NUM_PLAYERS * MAX_IDLE_ROUNDS);
  localparam logic [4:0]       LEN5       = 5'(BOARD_LEN);
  localparam logic [4:0]       LEN2       = 5'(2 * BOARD_LEN);

  state_t              state, state_nx;
  logic                start_prev;
  logic                armed;
  logic [TICK_W-1:0]   tick_cnt;
  logic [7:0]          idle_cnt;
  logic [DICE_W-1:0]   dice_q;

  logic                start_rise, accept, tick_wrap, timeout, idle_abort, clear_game;
  logic [3:0]          cur_pos, move_pos, evt_pos;
  logic [4:0]          sum, bsum;
  logic                bounce;
  logic [1:0]          evt_code;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (start_rise) state_nx = S_WAIT_DICE;
      S_WAIT_DICE: begin
        if (accept)          state_nx = S_MOVE;
        else if (idle_abort) state_nx = S_IDLE;
        else if (timeout)    state_nx = S_NEXT_TURN;
      end
      S_MOVE:      state_nx = S_EVENT;
      S_EVENT:     state_nx = (evt_pos == LEN5[3:0]) ? S_WIN : S_NEXT_TURN;
      S_NEXT_TURN: state_nx = S_WAIT_DICE;
      S_WIN:       if (start_rise) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Control strobes and move/event arithmetic (5-bit sums so nothing wraps before clamping)
  always_comb begin
    start_rise = start_btn & ~start_prev;
    accept     = (state == S_WAIT_DICE) && dice_valid && armed && (dice_value != '0);
    tick_wrap  = (state == S_WAIT_DICE) && !accept && (tick_cnt == TICK_LAST);
    timeout    = tick_wrap && (led_output == '0);
    idle_abort = timeout && (idle_cnt == IDLE_LIMIT - 8'd1);
    clear_game = idle_abort || ((state == S_WIN) && start_rise);

    cur_pos = '0;
    for (int k = 0; k < NUM_PLAYERS; k++)
      if (turn_id == 2'(k)) cur_pos = pos_bus[4*k +: 4];

    sum      = 5'(cur_pos) + 5'(dice_q);
    bounce   = 1'b0;
    move_pos = sum[3:0];
    if (sum > LEN5) begin
      if (EXACT_FINISH == 0) begin
        move_pos = LEN5[3:0];
      end else begin
        bounce   = 1'b1;
        move_pos = (sum >= LEN2) ? 4'd0 : 4'(LEN2 - sum);
      end
    end

    bsum     = 5'(cur_pos) + 5'(BOOST_AMT);
    evt_pos  = cur_pos;
    evt_code = event_code;
    if (cur_pos == 4'(TRAP_TILE)) begin
      evt_pos  = 4'd0;
      evt_code = 2'd1;
    end else if (cur_pos == 4'(BOOST_TILE)) begin
      evt_pos  = (bsum > LEN5) ? LEN5[3:0] : bsum[3:0];
      evt_code = 2'd2;
    end
  end

  // Game datapath: positions, turn, timers, handshake and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_bus      <= '0;
      turn_id      <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      event_code   <= '0;
      move_done    <= 1'b0;
      led_output   <= '1;
      start_prev   <= 1'b0;
      armed        <= 1'b1;
      tick_cnt     <= '0;
      idle_cnt     <= '0;
      dice_q       <= '0;
    end else begin
      start_prev <= start_btn;
      move_done  <= 1'b0;
      if (!dice_valid)  armed <= 1'b1;
      else if (accept)  armed <= 1'b0;

      if (clear_game) begin
        pos_bus      <= '0;
        turn_id      <= '0;
        winner_valid <= 1'b0;
        winner_id    <= '0;
        event_code   <= '0;
        led_output   <= '1;
        tick_cnt     <= '0;
        idle_cnt     <= '0;
      end else begin
        case (state)
          S_WAIT_DICE: begin
            if (accept) begin
              dice_q <= dice_value;
            end else if (tick_wrap) begin
              tick_cnt <= '0;
              if (timeout) idle_cnt   <= idle_cnt + 8'd1;
              else         led_output <= led_output << 1;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
          S_MOVE: begin
            for (int k = 0; k < NUM_PLAYERS; k++)
              if (turn_id == 2'(k)) pos_bus[4*k +: 4] <= move_pos;
            event_code <= bounce ? 2'd3 : 2'd0;
          end
          S_EVENT: begin
            for (int k = 0; k < NUM_PLAYERS; k++)
              if (turn_id == 2'(k)) pos_bus[4*k +: 4] <= evt_pos;
            event_code <= evt_code;
            move_done  <= 1'b1;
            idle_cnt   <= '0;
            if (evt_pos == LEN5[3:0]) begin
              winner_valid <= 1'b1;
              winner_id    <= turn_id;
            end
          end
          S_NEXT_TURN: begin
            turn_id    <= (turn_id == 2'(NUM_PLAYERS - 1)) ? 2'd0 : turn_id + 2'd1;
            tick_cnt   <= '0;
            led_output <= '1;
          end
          S_WIN: led_output <= '1;
          default: tick_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_engine_np.sv
// tb/tb_game_engine_np.sv - directed plus randomized checks of game_engine_np against a rule model
module tb_game_engine_np;

  logic clk = 1'b0;
  logic reset;
  logic st[2];
  logic dv[2];
  logic [1:0] dval[2];

  logic [7:0]  pos0;
  logic [11:0] pos1;
  logic [15:0] pb[2];
  logic [1:0]  tid[2], wid[2], ev[2];
  logic        wv[2], md[2];
  logic [15:0] led[2];

  int n_vec = 0;
  int n_err = 0;

  int np[2] = '{2, 3};
  int ex[2] = '{0, 1};
  int mpos[2][4];
  int mturn[2];
  int mwin[2];

  always #5 clk = ~clk;

  game_engine_np #(.NUM_PLAYERS(2), .TICK_CYCLES(4), .EXACT_FINISH(0)) dut0 (
    .clk(clk), .reset(reset), .start_btn(st[0]), .dice_valid(dv[0]), .dice_value(dval[0]),
    .pos_bus(pos0), .turn_id(tid[0]), .winner_valid(wv[0]), .winner_id(wid[0]),
    .event_code(ev[0]), .move_done(md[0]), .led_output(led[0]));

  game_engine_np #(.NUM_PLAYERS(3), .TICK_CYCLES(4), .EXACT_FINISH(1)) dut1 (
    .clk(clk), .reset(reset), .start_btn(st[1]), .dice_valid(dv[1]), .dice_value(dval[1]),
    .pos_bus(pos1), .turn_id(tid[1]), .winner_valid(wv[1]), .winner_id(wid[1]),
    .event_code(ev[1]), .move_done(md[1]), .led_output(led[1]));

  assign pb[0] = 16'(pos0);
  assign pb[1] = 16'(pos1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int get_pos(input int sel, input int t);
    return int'((pb[sel] >> (4 * t)) & 16'hf);
  endfunction

  // Board rules: finish 10, trap 4 -> 0, boost 7 -> +2 capped at 10
  function automatic void model_move(input int p, input int d, input int exact,
                                     output int mid, output int fin,
                                     output int ev_mid, output int ev_fin);
    int s;
    s = p + d;
    mid = s;
    ev_mid = 0;
    if (s > 10) begin
      if (exact == 0) mid = 10;
      else begin
        mid = 20 - s;
        if (mid < 0) mid = 0;
        ev_mid = 3;
      end
    end
    fin = mid;
    ev_fin = ev_mid;
    if (mid == 4) begin
      fin = 0;
      ev_fin = 1;
    end else if (mid == 7) begin
      fin = (mid + 2 > 10) ? 10 : mid + 2;
      ev_fin = 2;
    end
  endfunction

  task automatic new_game_model(input int sel);
    for (int k = 0; k < 4; k++) mpos[sel][k] = 0;
    mturn[sel] = 0;
    mwin[sel] = 0;
  endtask

  task automatic start_pulse(input int sel);
    st[sel] = 1'b1;
    @(posedge clk); #1;
    st[sel] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic roll(input int sel, input int v);
    int t, p, mid, fin, evm, evf;
    t = mturn[sel];
    p = mpos[sel][t];
    model_move(p, v, ex[sel], mid, fin, evm, evf);
    dv[sel] = 1'b1;
    dval[sel] = 2'(v);
    @(posedge clk); #1;
    dv[sel] = 1'b0;
    @(posedge clk); #1;
    check("move_pos", get_pos(sel, t), mid);
    check("move_event", ev[sel], evm);
    @(posedge clk); #1;
    check("move_done", md[sel], 1);
    check("event_pos", get_pos(sel, t), fin);
    check("event_code", ev[sel], evf);
    check("winner_valid", wv[sel], (fin == 10) ? 1 : 0);
    mpos[sel][t] = fin;
    if (fin == 10) begin
      check("winner_id", wid[sel], t);
      mwin[sel] = 1;
    end else begin
      @(posedge clk); #1;
      mturn[sel] = (t + 1) % np[sel];
      check("turn_id", tid[sel], mturn[sel]);
      check("move_done_low", md[sel], 0);
    end
  endtask

  task automatic random_game(input int sel);
    int guard;
    guard = 0;
    while (mwin[sel] == 0 && guard < 300) begin
      roll(sel, int'($urandom_range(1, 3)));
      guard++;
    end
    check("game_finished", mwin[sel], 1);
  endtask

  task automatic timeout_skip(input int sel);
    repeat (68) @(posedge clk);
    #1;
    check("timeout_turn_hold", tid[sel], mturn[sel]);
    @(posedge clk); #1;
    mturn[sel] = (mturn[sel] + 1) % np[sel];
    check("timeout_turn_next", tid[sel], mturn[sel]);
    check("timeout_led_refill", led[sel], 16'hffff);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; dv[i] = 1'b0; dval[i] = 2'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_pos", pb[i], 0);
      check("rst_turn", tid[i], 0);
      check("rst_winner", wv[i], 0);
      check("rst_event", ev[i], 0);
      check("rst_move_done", md[i], 0);
      check("rst_led", led[i], 16'hffff);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed opening on the 2-player clamp board
    start_pulse(0);
    new_game_model(0);
    check("start_turn", tid[0], 0);
    roll(0, 3);
    roll(0, 2);
    roll(0, 3);
    roll(0, 2);
    check("trap_pos", get_pos(0, 1), 0);
    check("trap_code", ev[0], 1);
    roll(0, 1);
    check("boost_pos", get_pos(0, 0), 9);
    check("boost_code", ev[0], 2);
    start_pulse(0);
    check("midgame_start_turn", tid[0], 1);
    check("midgame_start_pos", pb[0], 16'h0009);
    roll(0, 1);
    roll(0, 3);
    check("clamp_win_pos", get_pos(0, 0), 10);
    check("clamp_win_id", wid[0], 0);
    repeat (5) @(posedge clk);
    #1;
    check("win_hold_valid", wv[0], 1);
    check("win_hold_pos", get_pos(0, 0), 10);
    check("win_hold_led", led[0], 16'hffff);
    start_pulse(0);
    check("win_to_idle_pos", pb[0], 0);
    check("win_to_idle_valid", wv[0], 0);
    start_pulse(0);
    new_game_model(0);
    random_game(0);

    // 3-player bounce board, then idle abort
    start_pulse(1);
    new_game_model(1);
    roll(1, 3); roll(1, 1); roll(1, 1);
    roll(1, 3); roll(1, 1); roll(1, 1);
    roll(1, 1); roll(1, 1); roll(1, 1);
    roll(1, 3);
    check("bounce_pos", get_pos(1, 0), 8);
    check("bounce_code", ev[1], 3);
    check("bounce_no_win", wv[1], 0);
    random_game(1);
    start_pulse(1);
    check("win_to_idle_pos1", pb[1], 0);
    start_pulse(1);
    new_game_model(1);
    roll(1, 3);
    for (int i = 0; i < 5; i++) begin
      timeout_skip(1);
      check("idle_pos_kept", pb[1], 16'h0003);
    end
    repeat (68) @(posedge clk);
    #1;
    check("abort_pos", pb[1], 0);
    check("abort_turn", tid[1], 0);
    check("abort_led", led[1], 16'hffff);
    repeat (69) @(posedge clk);
    #1;
    check("abort_stays_idle", tid[1], 0);

    // Held dice_valid, illegal zero value, timeout on the 2-player board
    start_pulse(0);
    start_pulse(0);
    new_game_model(0);
    dv[0] = 1'b1; dval[0] = 2'd2;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      cnt += int'(md[0]);
    end
    check("held_valid_moves", cnt, 1);
    dv[0] = 1'b0;
    mpos[0][0] = 2;
    mturn[0] = 1;
    @(posedge clk); #1;
    check("held_valid_pos", pb[0], 16'h0002);
    check("held_valid_turn", tid[0], 1);
    dv[0] = 1'b1; dval[0] = 2'd0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      cnt += int'(md[0]);
    end
    check("zero_value_moves", cnt, 0);
    check("zero_value_pos", pb[0], 16'h0002);
    roll(0, 3);
    repeat (63) @(posedge clk);
    #1;
    check("led_last_step", led[0], 16'h8000);
    @(posedge clk); #1;
    check("led_empty", led[0], 16'h0000);
    check("led_empty_turn", tid[0], 0);
    repeat (4) @(posedge clk);
    #1;
    check("timeout_turn_hold0", tid[0], 0);
    @(posedge clk); #1;
    check("timeout_turn_next0", tid[0], 1);
    check("timeout_led_refill0", led[0], 16'hffff);

    // Asynchronous reset while in MOVE
    dv[0] = 1'b1; dval[0] = 2'd2;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("async_rst_pos", pb[0], 0);
    check("async_rst_turn", tid[0], 0);
    check("async_rst_led", led[0], 16'hffff);
    check("async_rst_event", ev[0], 0);
    check("async_rst_move_done", md[0], 0);
    check("async_rst_winner", wv[0], 0);
    dv[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    dv[0] = 1'b1; dval[0] = 2'd1;
    repeat (6) @(posedge clk);
    #1;
    check("idle_ignores_dice", pb[0], 0);
    dv[0] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
